// File: rtl/fb_sp_arbiter_pkg.sv
// Shared definitions for the single-port framebuffer arbiter: arbiter states,
// RAM word width and RAM read latency.
package fb_sp_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned RD_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_CLEAR_WAIT = 2'd1,
        ST_CLEAR      = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fb_sp_arbiter_if.sv
// Fragment-pipeline side of the arbiter: read request, read response and
// write request streams.
interface fb_sp_arbiter_if #(
    parameter int unsigned INDEX_WIDTH = 14
);

    logic                                   s_rd_valid;
    logic                                   s_rd_ready;
    logic [INDEX_WIDTH-1:0]                 s_rd_index;
    logic                                   m_rd_valid;
    logic [fb_sp_arbiter_pkg::DATA_WIDTH-1:0] m_rd_data;
    logic                                   s_wr_valid;
    logic                                   s_wr_ready;
    logic [INDEX_WIDTH-1:0]                 s_wr_index;
    logic [fb_sp_arbiter_pkg::DATA_WIDTH-1:0] s_wr_data;

    modport master (
        output s_rd_valid, s_rd_index, s_wr_valid, s_wr_index, s_wr_data,
        input  s_rd_ready, m_rd_valid, m_rd_data, s_wr_ready
    );

    modport slave (
        input  s_rd_valid, s_rd_index, s_wr_valid, s_wr_index, s_wr_data,
        output s_rd_ready, m_rd_valid, m_rd_data, s_wr_ready
    );

endinterface

// File: rtl/fb_sp_arbiter_write_buffer.sv
// Write-back FIFO in front of the framebuffer RAM, with a per-entry index
// compare against the incoming read address.
module fb_write_buffer
    import fb_sp_arbiter_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 14,
    parameter int unsigned DEPTH       = 4,
    localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [INDEX_WIDTH-1:0] push_index,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic                   pop,
    output logic [INDEX_WIDTH-1:0] head_index,
    output logic [DATA_WIDTH-1:0]  head_data,
    output logic [PTR_W:0]         count,
    input  logic [INDEX_WIDTH-1:0] match_index,
    output logic [DEPTH-1:0]       match
);

    logic [INDEX_WIDTH-1:0] idx_mem [DEPTH];
    logic [DATA_WIDTH-1:0]  dat_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wr_ptr] <= push_index;
            dat_mem[wr_ptr] <= push_data;
        end
    end

    assign head_index = idx_mem[rd_ptr];
    assign head_data  = dat_mem[rd_ptr];

    // An entry is live when its distance from the head is below the fill count.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count) && (idx_mem[i] == match_index);
        end
    end

endmodule

// File: rtl/fb_sp_arbiter.sv
// Single-port framebuffer arbiter: interleaves pipeline reads, buffered
// write-backs and a full-RAM clear onto one RAM port, one operation per cycle.
module fb_sp_arbiter
    import fb_sp_arbiter_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 14,
    parameter int unsigned WB_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    fb_sp_arbiter_if.slave         fb,
    input  logic                   clear_start,
    input  logic [DATA_WIDTH-1:0]  clear_data,
    output logic                   clear_busy,
    output logic                   idle,
    output logic [INDEX_WIDTH-1:0] mem_addr,
    output logic                   mem_wr_en,
    output logic [DATA_WIDTH-1:0]  mem_wr_data,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data
);

    localparam int unsigned PTR_W = $clog2(WB_DEPTH);

    arb_state_t             state;
    logic [INDEX_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0]  clr_data_q;
    logic [RD_LATENCY-1:0]  rd_pipe;
    logic                   rd_pend;
    logic [DATA_WIDTH-1:0]  rd_hold;

    logic [INDEX_WIDTH-1:0] wb_head_index;
    logic [DATA_WIDTH-1:0]  wb_head_data;
    logic [PTR_W:0]         wb_count;
    logic [WB_DEPTH-1:0]    wb_match;
    logic                   wb_full;
    logic                   wb_empty;
    logic                   hazard;
    logic                   rd_fire;
    logic                   wr_fire;
    logic                   drain;

    fb_write_buffer #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .DEPTH      (WB_DEPTH)
    ) u_wb (
        .clk        (clk),
        .resetn     (resetn),
        .push       (wr_fire),
        .push_index (fb.s_wr_index),
        .push_data  (fb.s_wr_data),
        .pop        (drain),
        .head_index (wb_head_index),
        .head_data  (wb_head_data),
        .count      (wb_count),
        .match_index(fb.s_rd_index),
        .match      (wb_match)
    );

    assign rd_pend = rd_pipe[RD_LATENCY-1];

    // A full buffer blocks reads, so the drain-when-not-reading rule also
    // covers the forced drain and the hazard drain.
    always_comb begin
        wb_full       = (wb_count == (PTR_W+1)'(WB_DEPTH));
        wb_empty      = (wb_count == '0);
        hazard        = |wb_match;
        fb.s_rd_ready = (state == ST_RUN) && !wb_full && !hazard;
        fb.s_wr_ready = (state == ST_RUN) && !wb_full;
        rd_fire       = fb.s_rd_valid && fb.s_rd_ready;
        wr_fire       = fb.s_wr_valid && fb.s_wr_ready;
        unique case (state)
            ST_RUN:        drain = !rd_fire && !wb_empty;
            ST_CLEAR_WAIT: drain = !wb_empty;
            default:       drain = 1'b0;
        endcase
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        if (drain) begin
            mem_addr    = wb_head_index;
            mem_wr_en   = 1'b1;
            mem_wr_data = wb_head_data;
        end else if (rd_fire) begin
            mem_addr = fb.s_rd_index;
        end else if (state == ST_CLEAR) begin
            mem_addr    = clr_cnt;
            mem_wr_en   = 1'b1;
            mem_wr_data = clr_data_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_RUN;
            clr_cnt    <= '0;
            clr_data_q <= '0;
            clear_busy <= 1'b0;
            rd_pipe    <= '0;
            rd_hold    <= '0;
        end else begin
            rd_pipe <= RD_LATENCY'({rd_pipe, rd_fire});
            if (rd_pend) rd_hold <= mem_rd_data;
            unique case (state)
                ST_RUN: begin
                    if (clear_start) begin
                        clr_data_q <= clear_data;
                        clear_busy <= 1'b1;
                        state      <= (wb_empty && !wr_fire) ? ST_CLEAR : ST_CLEAR_WAIT;
                    end
                end
                ST_CLEAR_WAIT: begin
                    if (wb_empty) state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state      <= ST_RUN;
                        clear_busy <= 1'b0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign fb.m_rd_valid = rd_pend;
    assign fb.m_rd_data  = rd_pend ? mem_rd_data : rd_hold;
    assign idle          = (state == ST_RUN) && wb_empty && !rd_pend;

endmodule

// File: tb/tb_fb_sp_arbiter.sv
// Self-checking bench for fb_sp_arbiter: vector table, directed corner
// sequences and a randomized run against an architectural memory model.
module tb_fb_sp_arbiter;

    localparam int unsigned IW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WORDS = 1 << IW;

    logic            clk = 1'b0;
    logic            resetn;
    logic            clear_start;
    logic [15:0]     clear_data;
    logic            clear_busy;
    logic            idle;
    logic [IW-1:0]   mem_addr;
    logic            mem_wr_en;
    logic [15:0]     mem_wr_data;
    logic [15:0]     mem_rd_data;
    logic            preload;
    logic [15:0]     ram [WORDS];

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    fb_sp_arbiter_if #(.INDEX_WIDTH(IW)) fb ();

    fb_sp_arbiter #(
        .INDEX_WIDTH(IW),
        .WB_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .fb         (fb),
        .clear_start(clear_start),
        .clear_data (clear_data),
        .clear_busy (clear_busy),
        .idle       (idle),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // SPRAM model: registered read data, write cycles leave the output alone.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= 16'hA000 + 16'(i);
        end else if (mem_wr_en) begin
            ram[mem_addr] <= mem_wr_data;
        end else begin
            mem_rd_data <= ram[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rv;  logic [IW-1:0] ri;
        logic          wv;  logic [IW-1:0] wi; logic [15:0] wd;
        logic          e_rrdy; logic e_wrdy; logic e_we;
        logic [IW-1:0] e_addr; logic [15:0] e_wdata;
        logic          e_mv;  logic [15:0] e_md;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rv, input int ri, input logic wv, input int wi,
                                input int wd, input logic rr, input logic wr, input logic we,
                                input int addr, input int wdat, input logic mv, input int md);
        vec_t v;
        v.rv = rv; v.ri = IW'(ri); v.wv = wv; v.wi = IW'(wi); v.wd = 16'(wd);
        v.e_rrdy = rr; v.e_wrdy = wr; v.e_we = we; v.e_addr = IW'(addr);
        v.e_wdata = 16'(wdat); v.e_mv = mv; v.e_md = 16'(md);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rv, input logic [IW-1:0] ri, input logic wv,
                          input logic [IW-1:0] wi, input logic [15:0] wd);
        fb.s_rd_valid = rv;
        fb.s_rd_index = ri;
        fb.s_wr_valid = wv;
        fb.s_wr_index = wi;
        fb.s_wr_data  = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read, holding it until accepted; returns data and stall cycles.
    task automatic do_read(input logic [IW-1:0] idx, output logic [15:0] d,
                           output int unsigned waits);
        waits = 0;
        set_in(1'b1, idx, 1'b0, '0, '0);
        #1;
        while (!fb.s_rd_ready && waits < 10) begin
            tick();
            waits++;
            #1;
        end
        tick();
        set_in(1'b0, '0, 1'b0, '0, '0);
        #1;
        chk("rd_resp_valid", 32'(fb.m_rd_valid), 32'd1);
        d = fb.m_rd_data;
    endtask

    initial begin
        logic [15:0]   d;
        int unsigned   w;
        int unsigned   busy_cycles;
        logic          blocked_ok;
        logic          found;
        logic [15:0]   arch [WORDS];
        logic [IW-1:0] mq_idx [$];
        logic [15:0]   mq_dat [$];
        logic          prev_acc;
        logic [15:0]   prev_exp;

        resetn = 1'b0; preload = 1'b1; clear_start = 1'b0; clear_data = '0;
        set_in(1'b0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        chk("rst_m_rd_valid", 32'(fb.m_rd_valid), 32'd0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
        chk("rst_clear_busy", 32'(clear_busy), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        resetn = 1'b1;
        tick();

        // back-to-back reads of 0..7, then reads with 5 writes into a 4-deep buffer
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, k, 0, 0, 0, 1, 1, 0, k, 0, k > 0, 'hA000 + k - 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 'hA007));
        vecs.push_back(mk(1,  8, 1, 0, 'hB000, 1, 1, 0,  8, 0,       0, 0));
        vecs.push_back(mk(1,  9, 1, 1, 'hB001, 1, 1, 0,  9, 0,       1, 'hA008));
        vecs.push_back(mk(1, 10, 1, 2, 'hB002, 1, 1, 0, 10, 0,       1, 'hA009));
        vecs.push_back(mk(1, 11, 1, 3, 'hB003, 1, 1, 0, 11, 0,       1, 'hA00A));
        vecs.push_back(mk(1, 12, 1, 4, 'hB004, 0, 0, 1,  0, 'hB000,  1, 'hA00B));
        vecs.push_back(mk(1, 12, 1, 4, 'hB004, 1, 1, 0, 12, 0,       0, 0));
        vecs.push_back(mk(1, 13, 0, 0, 0,      0, 0, 1,  1, 'hB001,  1, 'hA00C));
        vecs.push_back(mk(1, 13, 0, 0, 0,      1, 1, 0, 13, 0,       0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,      1, 1, 1,  2, 'hB002,  1, 'hA00D));
        vecs.push_back(mk(0,  0, 0, 0, 0,      1, 1, 1,  3, 'hB003,  0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,      1, 1, 1,  4, 'hB004,  0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,      1, 1, 0,  0, 0,       0, 0));

        foreach (vecs[i]) begin
            set_in(vecs[i].rv, vecs[i].ri, vecs[i].wv, vecs[i].wi, vecs[i].wd);
            #1;
            chk($sformatf("v%0d_rd_ready", i), 32'(fb.s_rd_ready), 32'(vecs[i].e_rrdy));
            chk($sformatf("v%0d_wr_ready", i), 32'(fb.s_wr_ready), 32'(vecs[i].e_wrdy));
            chk($sformatf("v%0d_mem_wr_en", i), 32'(mem_wr_en), 32'(vecs[i].e_we));
            if (vecs[i].e_we || (vecs[i].rv && vecs[i].e_rrdy))
                chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            if (vecs[i].e_we)
                chk($sformatf("v%0d_mem_wr_data", i), 32'(mem_wr_data), 32'(vecs[i].e_wdata));
            chk($sformatf("v%0d_m_rd_valid", i), 32'(fb.m_rd_valid), 32'(vecs[i].e_mv));
            if (vecs[i].e_mv)
                chk($sformatf("v%0d_m_rd_data", i), 32'(fb.m_rd_data), 32'(vecs[i].e_md));
            tick();
        end
        for (int k = 0; k < 5; k++)
            chk($sformatf("wb_order_ram%0d", k), 32'(ram[k]), 32'(16'hB000 + 16'(k)));

        // read-after-write hazard on index 0xA
        set_in(1'b0, '0, 1'b1, 4'hA, 16'hBEEF);
        tick();
        set_in(1'b1, 4'hA, 1'b0, '0, '0);
        #1;
        chk("haz_rd_ready", 32'(fb.s_rd_ready), 32'd0);
        chk("haz_drain_we", 32'(mem_wr_en), 32'd1);
        chk("haz_drain_addr", 32'(mem_addr), 32'hA);
        tick();
        do_read(4'hA, d, w);
        chk("haz_wait", w, 32'd0);
        chk("haz_data", 32'(d), 32'hBEEF);
        tick();

        // same-cycle read and write to index 6: read returns the old contents
        set_in(1'b0, '0, 1'b1, 4'h6, 16'h1111);
        tick();
        set_in(1'b0, '0, 1'b0, '0, '0);
        tick();
        tick();
        set_in(1'b1, 4'h6, 1'b1, 4'h6, 16'h2222);
        #1;
        chk("same_rd_ready", 32'(fb.s_rd_ready), 32'd1);
        chk("same_wr_ready", 32'(fb.s_wr_ready), 32'd1);
        tick();
        set_in(1'b0, '0, 1'b0, '0, '0);
        #1;
        chk("same_old_valid", 32'(fb.m_rd_valid), 32'd1);
        chk("same_old_data", 32'(fb.m_rd_data), 32'h1111);
        tick();
        tick();
        do_read(4'h6, d, w);
        chk("same_new_data", 32'(d), 32'h2222);
        tick();

        // clear with two buffered writes and a read in the start cycle
        set_in(1'b1, 4'd13, 1'b1, 4'd1, 16'hC001);
        tick();
        set_in(1'b1, 4'd14, 1'b1, 4'd2, 16'hC002);
        tick();
        set_in(1'b1, 4'd15, 1'b0, '0, '0);
        clear_start = 1'b1; clear_data = 16'h0F0F;
        #1;
        chk("clr_start_rd_ready", 32'(fb.s_rd_ready), 32'd1);
        tick();
        clear_start = 1'b0; clear_data = '0;
        set_in(1'b0, '0, 1'b0, '0, '0);
        #1;
        chk("clr_rd_valid", 32'(fb.m_rd_valid), 32'd1);
        chk("clr_rd_data", 32'(fb.m_rd_data), 32'hA00F);
        busy_cycles = 0; blocked_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!clear_busy) break;
            busy_cycles++;
            if (fb.s_rd_ready || fb.s_wr_ready) blocked_ok = 1'b0;
            tick();
            clear_start = (busy_cycles == 10);
            clear_data  = (busy_cycles == 10) ? 16'h5555 : 16'h0000;
            #1;
        end
        chk("clr_busy_cycles", busy_cycles, 32'd19);
        chk("clr_ports_blocked", 32'(blocked_ok), 32'd1);
        chk("clr_idle_after", 32'(idle), 32'd1);
        for (int k = 0; k < WORDS; k++)
            chk($sformatf("clr_ram%0d", k), 32'(ram[k]), 32'h0F0F);
        tick();

        // reset while the fill is writing address 7
        clear_start = 1'b1; clear_data = 16'h7777;
        tick();
        clear_start = 1'b0; clear_data = '0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (mem_wr_en && mem_addr == 4'd7) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_clr_reached7", 32'(found), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_clear_busy", 32'(clear_busy), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_m_rd_valid", 32'(fb.m_rd_valid), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        for (int k = 0; k < 7; k++)
            chk($sformatf("mid_ram%0d_filled", k), 32'(ram[k]), 32'h7777);
        for (int k = 8; k < WORDS; k++)
            chk($sformatf("mid_ram%0d_kept", k), 32'(ram[k]), 32'h0F0F);
        do_read(4'd3, d, w);
        chk("mid_rd_wait", w, 32'd0);
        chk("mid_rd_data", 32'(d), 32'h7777);
        tick();

        // randomized traffic against an architectural memory model
        for (int k = 0; k < WORDS; k++) arch[k] = ram[k];
        prev_acc = 1'b0; prev_exp = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic rv, wv, full, haz, rd_acc, wr_acc, drn;
            logic [IW-1:0] ri, wi;
            logic [15:0] wd;
            rv = ($urandom_range(0, 3) != 0);
            wv = ($urandom_range(0, 1) != 0);
            ri = IW'($urandom_range(0, 5));
            wi = IW'($urandom_range(0, 5));
            wd = 16'($urandom);
            set_in(rv, ri, wv, wi, wd);
            #1;
            full = (mq_idx.size() == DEPTH);
            haz = 1'b0;
            foreach (mq_idx[j]) if (mq_idx[j] == ri) haz = 1'b1;
            chk("rnd_rd_ready", 32'(fb.s_rd_ready), 32'(!full && !haz));
            chk("rnd_wr_ready", 32'(fb.s_wr_ready), 32'(!full));
            chk("rnd_m_rd_valid", 32'(fb.m_rd_valid), 32'(prev_acc));
            if (prev_acc) chk("rnd_m_rd_data", 32'(fb.m_rd_data), 32'(prev_exp));
            chk("rnd_idle", 32'(idle), 32'(mq_idx.size() == 0 && !prev_acc));
            rd_acc = rv && !full && !haz;
            wr_acc = wv && !full;
            drn    = full || (!rd_acc && mq_idx.size() > 0);
            chk("rnd_mem_wr_en", 32'(mem_wr_en), 32'(drn));
            if (drn) begin
                chk("rnd_drain_addr", 32'(mem_addr), 32'(mq_idx[0]));
                chk("rnd_drain_data", 32'(mem_wr_data), 32'(mq_dat[0]));
                void'(mq_idx.pop_front());
                void'(mq_dat.pop_front());
            end else if (rd_acc) begin
                chk("rnd_rd_addr", 32'(mem_addr), 32'(ri));
            end
            prev_acc = rd_acc;
            if (rd_acc) prev_exp = arch[ri];
            if (wr_acc) begin
                mq_idx.push_back(wi);
                mq_dat.push_back(wd);
                arch[wi] = wd;
            end
            tick();
        end
        set_in(1'b0, '0, 1'b0, '0, '0);
        repeat (6) tick();
        for (int k = 0; k < WORDS; k++)
            chk($sformatf("rnd_final_ram%0d", k), 32'(ram[k]), 32'(arch[k]));
        chk("rnd_final_idle", 32'(idle), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
